// File: rtl/core_pkg.sv
// Core-wide shared types: CSR address/operation, Zicsr funct3 encodings,
// and the CSR access unit state encoding.
package core_pkg;

   typedef logic [11:0] csr_addr_t;

   typedef enum logic [1:0] {
      CSR_READ  = 2'd0,
      CSR_WRITE = 2'd1,
      CSR_SET   = 2'd2,
      CSR_CLEAR = 2'd3
   } csr_operation_t;

   localparam logic [2:0] CSR_F3_RW  = 3'b001;
   localparam logic [2:0] CSR_F3_RS  = 3'b010;
   localparam logic [2:0] CSR_F3_RC  = 3'b011;
   localparam logic [2:0] CSR_F3_RWI = 3'b101;
   localparam logic [2:0] CSR_F3_RSI = 3'b110;
   localparam logic [2:0] CSR_F3_RCI = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ISSUE = 2'd2,
      ST_RESP  = 2'd3
   } csr_unit_state_t;

endpackage

// File: rtl/csr_op_decoder.sv
// Combinational Zicsr decode: funct3/addr/rs1 -> CSR op, write data, illegal.
// Optional address legality checks are enabled with CSR_ILLEGAL_CHECK_EN.
module csr_op_decoder
   import core_pkg::*;
(
   input  logic [2:0]     funct3_i,
   input  csr_addr_t      csr_addr_i,
   input  logic [31:0]    rs1_data_i,
   input  logic [4:0]     rs1_idx_i,
   output csr_operation_t op_o,
   output logic [31:0]    wdata_o,
   output logic           illegal_o
);

   csr_operation_t op;
   logic [31:0]    wdata;
   logic           illegal;

   // Decode funct3, then suppress no-op set/clear, then apply legality
   always_comb begin
      op      = CSR_READ;
      wdata   = rs1_data_i;
      illegal = 1'b0;
      case (funct3_i)
         CSR_F3_RW:  op = CSR_WRITE;
         CSR_F3_RS:  op = CSR_SET;
         CSR_F3_RC:  op = CSR_CLEAR;
         CSR_F3_RWI: begin op = CSR_WRITE; wdata = {27'b0, rs1_idx_i}; end
         CSR_F3_RSI: begin op = CSR_SET;   wdata = {27'b0, rs1_idx_i}; end
         CSR_F3_RCI: begin op = CSR_CLEAR; wdata = {27'b0, rs1_idx_i}; end
         default:    illegal = 1'b1;
      endcase
      // Set/clear with x0 or uimm 0 must not write (no side effects)
      if ((op == CSR_SET || op == CSR_CLEAR) && rs1_idx_i == 5'd0)
         op = CSR_READ;
`ifdef CSR_ILLEGAL_CHECK_EN
      // Writes to read-only space, or any non-machine CSR on this M-only core
      if (op != CSR_READ && csr_addr_i[11:10] == 2'b11) illegal = 1'b1;
      if (csr_addr_i[9:8] != 2'b11)                     illegal = 1'b1;
`endif
      if (illegal) op = CSR_READ;
   end

`ifndef CSR_ILLEGAL_CHECK_EN
   logic unused_addr;
   assign unused_addr = ^csr_addr_i;
`endif

   assign op_o      = op;
   assign wdata_o   = wdata;
   assign illegal_o = illegal;

endmodule

// File: rtl/csr_access_unit.sv
// CSR access initiator: serializes Zicsr instructions against the pipeline,
// issues one access cycle to the CSR file and holds a writeback response.
// Optional macro CSR_ILLEGAL_CHECK_EN enables address legality checks.
module csr_access_unit
   import core_pkg::*;
#(
   parameter bit SERIALIZE = 1'b1
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           req_valid_i,
   output logic           req_ready_o,
   input  logic [2:0]     req_funct3_i,
   input  csr_addr_t      req_csr_addr_i,
   input  logic [31:0]    req_rs1_data_i,
   input  logic [4:0]     req_rs1_idx_i,
   input  logic [4:0]     req_rd_idx_i,
   input  logic           pipe_empty_i,
   output csr_addr_t      csr_addr_o,
   output logic [31:0]    csr_wdata_o,
   output csr_operation_t csr_op_o,
   input  logic [31:0]    csr_rdata_i,
   output logic           rsp_valid_o,
   input  logic           rsp_ready_i,
   output logic [4:0]     rsp_rd_idx_o,
   output logic [31:0]    rsp_rd_data_o,
   output logic           rsp_rd_we_o,
   output logic           rsp_illegal_o,
   output logic           busy_o
);

   csr_unit_state_t state_q, state_d;
   logic [2:0]      f3_q, f3_d;
   csr_addr_t       addr_q, addr_d;
   logic [31:0]     rs1_data_q, rs1_data_d;
   logic [4:0]      rs1_idx_q, rs1_idx_d;
   logic [4:0]      rd_idx_q, rd_idx_d;
   csr_addr_t       csr_addr_q, csr_addr_d;
   logic [31:0]     csr_wdata_q, csr_wdata_d;
   csr_operation_t  csr_op_q, csr_op_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [4:0]      rsp_rd_idx_q, rsp_rd_idx_d;
   logic [31:0]     rsp_rd_data_q, rsp_rd_data_d;
   logic            rsp_rd_we_q, rsp_rd_we_d;
   logic            rsp_illegal_q, rsp_illegal_d;

   // In IDLE decode the live request so ISSUE can follow immediately;
   // otherwise decode the latched copy.
   logic           in_idle;
   csr_operation_t dec_op;
   logic [31:0]    dec_wdata;
   logic           dec_illegal;
   csr_addr_t      dec_addr;

   assign in_idle  = (state_q == ST_IDLE);
   assign dec_addr = in_idle ? req_csr_addr_i : addr_q;

   csr_op_decoder u_dec (
      .funct3_i   (in_idle ? req_funct3_i   : f3_q),
      .csr_addr_i (dec_addr),
      .rs1_data_i (in_idle ? req_rs1_data_i : rs1_data_q),
      .rs1_idx_i  (in_idle ? req_rs1_idx_i  : rs1_idx_q),
      .op_o       (dec_op),
      .wdata_o    (dec_wdata),
      .illegal_o  (dec_illegal)
   );

   // Next-state: accept, drain, single-cycle issue, hold response
   always_comb begin
      state_d       = state_q;
      f3_d          = f3_q;
      addr_d        = addr_q;
      rs1_data_d    = rs1_data_q;
      rs1_idx_d     = rs1_idx_q;
      rd_idx_d      = rd_idx_q;
      csr_addr_d    = csr_addr_q;
      csr_wdata_d   = csr_wdata_q;
      csr_op_d      = CSR_READ;
      rsp_valid_d   = rsp_valid_q;
      rsp_rd_idx_d  = rsp_rd_idx_q;
      rsp_rd_data_d = rsp_rd_data_q;
      rsp_rd_we_d   = rsp_rd_we_q;
      rsp_illegal_d = rsp_illegal_q;
      case (state_q)
         ST_IDLE: if (req_valid_i) begin
            f3_d       = req_funct3_i;
            addr_d     = req_csr_addr_i;
            rs1_data_d = req_rs1_data_i;
            rs1_idx_d  = req_rs1_idx_i;
            rd_idx_d   = req_rd_idx_i;
            if (SERIALIZE && !pipe_empty_i) begin
               state_d = ST_DRAIN;
            end else begin
               state_d     = ST_ISSUE;
               csr_addr_d  = dec_addr;
               csr_wdata_d = dec_wdata;
               csr_op_d    = dec_op;
            end
         end
         ST_DRAIN: if (pipe_empty_i) begin
            state_d     = ST_ISSUE;
            csr_addr_d  = dec_addr;
            csr_wdata_d = dec_wdata;
            csr_op_d    = dec_op;
         end
         ST_ISSUE: begin
            state_d       = ST_RESP;
            rsp_valid_d   = 1'b1;
            rsp_rd_idx_d  = rd_idx_q;
            rsp_rd_data_d = dec_illegal ? 32'd0 : csr_rdata_i;
            rsp_rd_we_d   = (rd_idx_q != 5'd0) && !dec_illegal;
            rsp_illegal_d = dec_illegal;
         end
         ST_RESP: if (rsp_ready_i) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs, async active-low reset
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= ST_IDLE;
         f3_q          <= '0;
         addr_q        <= '0;
         rs1_data_q    <= '0;
         rs1_idx_q     <= '0;
         rd_idx_q      <= '0;
         csr_addr_q    <= '0;
         csr_wdata_q   <= '0;
         csr_op_q      <= CSR_READ;
         rsp_valid_q   <= 1'b0;
         rsp_rd_idx_q  <= '0;
         rsp_rd_data_q <= '0;
         rsp_rd_we_q   <= 1'b0;
         rsp_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         f3_q          <= f3_d;
         addr_q        <= addr_d;
         rs1_data_q    <= rs1_data_d;
         rs1_idx_q     <= rs1_idx_d;
         rd_idx_q      <= rd_idx_d;
         csr_addr_q    <= csr_addr_d;
         csr_wdata_q   <= csr_wdata_d;
         csr_op_q      <= csr_op_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rd_idx_q  <= rsp_rd_idx_d;
         rsp_rd_data_q <= rsp_rd_data_d;
         rsp_rd_we_q   <= rsp_rd_we_d;
         rsp_illegal_q <= rsp_illegal_d;
      end
   end

   assign req_ready_o   = in_idle;
   assign busy_o        = !in_idle;
   assign csr_addr_o    = csr_addr_q;
   assign csr_wdata_o   = csr_wdata_q;
   assign csr_op_o      = csr_op_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rd_idx_o  = rsp_rd_idx_q;
   assign rsp_rd_data_o = rsp_rd_data_q;
   assign rsp_rd_we_o   = rsp_rd_we_q;
   assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small behavioural CSR file.
module tb_csr_access_unit;
   import core_pkg::*;

   logic           clk_i = 1'b0;
   logic           rst_n_i = 1'b0;
   logic           req_valid_i = 1'b0;
   logic           req_ready_o;
   logic [2:0]     req_funct3_i = '0;
   csr_addr_t      req_csr_addr_i = '0;
   logic [31:0]    req_rs1_data_i = '0;
   logic [4:0]     req_rs1_idx_i = '0;
   logic [4:0]     req_rd_idx_i = '0;
   logic           pipe_empty_i = 1'b1;
   csr_addr_t      csr_addr_o;
   logic [31:0]    csr_wdata_o;
   csr_operation_t csr_op_o;
   logic [31:0]    csr_rdata_i;
   logic           rsp_valid_o;
   logic           rsp_ready_i = 1'b0;
   logic [4:0]     rsp_rd_idx_o;
   logic [31:0]    rsp_rd_data_o;
   logic           rsp_rd_we_o;
   logic           rsp_illegal_o;
   logic           busy_o;

   csr_access_unit dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_funct3_i(req_funct3_i), .req_csr_addr_i(req_csr_addr_i),
      .req_rs1_data_i(req_rs1_data_i), .req_rs1_idx_i(req_rs1_idx_i),
      .req_rd_idx_i(req_rd_idx_i), .pipe_empty_i(pipe_empty_i),
      .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o), .csr_op_o(csr_op_o),
      .csr_rdata_i(csr_rdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rd_idx_o(rsp_rd_idx_o), .rsp_rd_data_o(rsp_rd_data_o),
      .rsp_rd_we_o(rsp_rd_we_o), .rsp_illegal_o(rsp_illegal_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural CSR file: misa, mtvec, mscratch; everything else reads 0
   logic [31:0] m_misa = 32'h4000_1100;
   logic [31:0] m_mtvec = 32'h0;
   logic [31:0] m_mscratch = 32'h0;

   always_comb begin
      csr_rdata_i = 32'h0;
      case (csr_addr_o)
         12'h301: csr_rdata_i = m_misa;
         12'h305: csr_rdata_i = m_mtvec;
         12'h340: csr_rdata_i = m_mscratch;
         default: csr_rdata_i = 32'h0;
      endcase
   end

   function automatic logic [31:0] apply_op(input logic [31:0] old, input csr_operation_t op,
                                            input logic [31:0] wd);
      case (op)
         CSR_WRITE: return wd;
         CSR_SET:   return old | wd;
         CSR_CLEAR: return old & ~wd;
         default:   return old;
      endcase
   endfunction

   always @(posedge clk_i) begin
      if (csr_addr_o == 12'h305) m_mtvec <= apply_op(m_mtvec, csr_op_o, csr_wdata_o);
      if (csr_addr_o == 12'h340) m_mscratch <= apply_op(m_mscratch, csr_op_o, csr_wdata_o);
   end

   // Watch for any non-read op while the reset sequence runs
   logic mon_en = 1'b0;
   logic mon_bad = 1'b0;
   always @(posedge clk_i) if (mon_en && csr_op_o != CSR_READ) mon_bad <= 1'b1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]     f3;
      logic [11:0]    addr;
      logic [31:0]    rs1_data;
      logic [4:0]     rs1_idx;
      logic [4:0]     rd;
      csr_operation_t exp_op;
      logic [31:0]    exp_wdata;
      logic           exp_ill;
      logic           exp_we;
      logic [31:0]    exp_rdata;
   } vec_t;

   task automatic drive_req(input logic [2:0] f3, input logic [11:0] addr,
                            input logic [31:0] d, input logic [4:0] i1, input logic [4:0] rd);
      req_valid_i    = 1'b1;
      req_funct3_i   = f3;
      req_csr_addr_i = addr;
      req_rs1_data_i = d;
      req_rs1_idx_i  = i1;
      req_rd_idx_i   = rd;
   endtask

   task automatic run_vec(input vec_t v, input int k);
      string s;
      s = $sformatf("v%0d", k);
      @(negedge clk_i);
      drive_req(v.f3, v.addr, v.rs1_data, v.rs1_idx, v.rd);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      chk({s, "_issue_op"}, 32'(csr_op_o), 32'(v.exp_op));
      chk({s, "_issue_addr"}, 32'(csr_addr_o), 32'(v.addr));
      if (!v.exp_ill) chk({s, "_issue_wdata"}, csr_wdata_o, v.exp_wdata);
      chk({s, "_issue_rdy"}, 32'(req_ready_o), 32'd0);
      chk({s, "_issue_rspv"}, 32'(rsp_valid_o), 32'd0);
      @(posedge clk_i); #1;
      chk({s, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
      chk({s, "_rsp_rd"}, 32'(rsp_rd_idx_o), 32'(v.rd));
      chk({s, "_rsp_data"}, rsp_rd_data_o, v.exp_rdata);
      chk({s, "_rsp_we"}, 32'(rsp_rd_we_o), 32'(v.exp_we));
      chk({s, "_rsp_ill"}, 32'(rsp_illegal_o), 32'(v.exp_ill));
      chk({s, "_rsp_op_read"}, 32'(csr_op_o), 32'(CSR_READ));
      @(negedge clk_i); rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
      chk({s, "_done_rspv"}, 32'(rsp_valid_o), 32'd0);
      chk({s, "_done_rdy"}, 32'(req_ready_o), 32'd1);
   endtask

   vec_t vecs[10];

   initial begin
      // Table: pipe empty, response accepted immediately; model state carries over
      vecs[0] = '{CSR_F3_RS,  12'h301, 32'h0000_DEAD, 5'd0,  5'd5, CSR_READ,  32'h0000_DEAD, 1'b0, 1'b1, 32'h4000_1100};
      vecs[1] = '{CSR_F3_RW,  12'h305, 32'h8000_0100, 5'd7,  5'd0, CSR_WRITE, 32'h8000_0100, 1'b0, 1'b0, 32'h0};
      vecs[2] = '{CSR_F3_RS,  12'h340, 32'h0000_00F0, 5'd1,  5'd6, CSR_SET,   32'h0000_00F0, 1'b0, 1'b1, 32'h0};
      vecs[3] = '{CSR_F3_RC,  12'h340, 32'h0000_0030, 5'd2,  5'd7, CSR_CLEAR, 32'h0000_0030, 1'b0, 1'b1, 32'h0000_00F0};
      vecs[4] = '{CSR_F3_RWI, 12'h340, 32'hFFFF_FFFF, 5'd5,  5'd8, CSR_WRITE, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_00C0};
      vecs[5] = '{CSR_F3_RSI, 12'h340, 32'hFFFF_FFFF, 5'd0,  5'd9, CSR_READ,  32'h0000_0000, 1'b0, 1'b1, 32'h0000_0005};
      vecs[6] = '{CSR_F3_RSI, 12'h340, 32'h0,         5'h18, 5'd9, CSR_SET,   32'h0000_0018, 1'b0, 1'b1, 32'h0000_0005};
      vecs[7] = '{3'b100,     12'h340, 32'h1234_5678, 5'd3,  5'd4, CSR_READ,  32'h0,         1'b1, 1'b0, 32'h0};
      vecs[8] = '{3'b000,     12'h301, 32'h1234_5678, 5'd3,  5'd4, CSR_READ,  32'h0,         1'b1, 1'b0, 32'h0};
`ifdef CSR_ILLEGAL_CHECK_EN
      vecs[9] = '{CSR_F3_RW,  12'hF14, 32'h0000_0055, 5'd2,  5'd1, CSR_READ,  32'h0,         1'b1, 1'b0, 32'h0};
`else
      vecs[9] = '{CSR_F3_RW,  12'hF14, 32'h0000_0055, 5'd2,  5'd1, CSR_WRITE, 32'h0000_0055, 1'b0, 1'b1, 32'h0};
`endif

      // Reset state
      #12;
      chk("rst_ready", 32'(req_ready_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_rspv", 32'(rsp_valid_o), 32'd0);
      chk("rst_op", 32'(csr_op_o), 32'(CSR_READ));
      chk("rst_addr", 32'(csr_addr_o), 32'd0);
      chk("rst_wdata", csr_wdata_o, 32'd0);
      chk("rst_rsp", {rsp_rd_data_o[26:0], rsp_rd_idx_o}, 32'd0);
      chk("rst_we_ill", {30'd0, rsp_rd_we_o, rsp_illegal_o}, 32'd0);
      @(negedge clk_i); rst_n_i = 1'b1;

      for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

      // Drain: CSRRCI x3, mtvec, uimm 0x1F with pipe busy for 4 cycles
      @(negedge clk_i);
      pipe_empty_i = 1'b0;
      drive_req(CSR_F3_RCI, 12'h305, 32'h0, 5'h1F, 5'd3);
      @(posedge clk_i);
      for (int c = 0; c < 4; c++) begin
         #1;
         req_valid_i = 1'b0;
         chk($sformatf("drain%0d_busy", c), {30'd0, busy_o, req_ready_o}, 32'd2);
         chk($sformatf("drain%0d_op", c), 32'(csr_op_o), 32'(CSR_READ));
         if (c == 3) pipe_empty_i = 1'b1;
         @(posedge clk_i);
      end
      #1;
      chk("drain_issue_op", 32'(csr_op_o), 32'(CSR_CLEAR));
      chk("drain_issue_wdata", csr_wdata_o, 32'h0000_001F);
      @(posedge clk_i); #1;
      chk("drain_rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("drain_rsp_data", rsp_rd_data_o, 32'h8000_0100);
      chk("drain_rsp_rd_we", {26'd0, rsp_rd_idx_o, rsp_rd_we_o}, {26'd0, 5'd3, 1'b1});
      @(negedge clk_i); rsp_ready_i = 1'b1;
      @(posedge clk_i); #1; rsp_ready_i = 1'b0;

      // Backpressure: read mscratch (0x1D), hold rsp 5 cycles, next req waiting
      @(negedge clk_i);
      drive_req(CSR_F3_RS, 12'h340, 32'h0, 5'd0, 5'd10);
      @(posedge clk_i); #1;
      drive_req(CSR_F3_RWI, 12'h340, 32'h0, 5'd3, 5'd11);
      @(posedge clk_i);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp%0d_valid_rdy", c), {30'd0, rsp_valid_o, req_ready_o}, 32'd2);
         chk($sformatf("bp%0d_data", c), rsp_rd_data_o, 32'h0000_001D);
         chk($sformatf("bp%0d_rd", c), 32'(rsp_rd_idx_o), 32'd10);
         @(posedge clk_i);
      end
      @(negedge clk_i); rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
      chk("bp_hs_valid_rdy", {30'd0, rsp_valid_o, req_ready_o}, 32'd1);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      chk("bp_next_op", 32'(csr_op_o), 32'(CSR_WRITE));
      chk("bp_next_wdata", csr_wdata_o, 32'h0000_0003);
      @(posedge clk_i); #1;
      chk("bp_next_rsp", rsp_rd_data_o, 32'h0000_001D);
      @(negedge clk_i); rsp_ready_i = 1'b1;
      @(posedge clk_i); #1; rsp_ready_i = 1'b0;

      // Reset during DRAIN: no write may ever reach the CSR file
      mon_en = 1'b1;
      @(negedge clk_i);
      pipe_empty_i = 1'b0;
      drive_req(CSR_F3_RW, 12'h340, 32'h0000_AAAA, 5'd4, 5'd1);
      @(posedge clk_i); #1; req_valid_i = 1'b0;
      chk("rd_in_drain", 32'(busy_o), 32'd1);
      @(posedge clk_i); #3;
      rst_n_i = 1'b0;
      #1;
      chk("rd_rst_busy_rdy", {30'd0, busy_o, req_ready_o}, 32'd1);
      chk("rd_rst_op", 32'(csr_op_o), 32'(CSR_READ));
      chk("rd_rst_addr_wdata", {20'd0, csr_addr_o} | csr_wdata_o, 32'd0);
      chk("rd_rst_rsp", {25'd0, rsp_valid_o, rsp_rd_we_o, rsp_illegal_o, rsp_rd_idx_o[3:0]}, 32'd0);
      pipe_empty_i = 1'b1;
      @(negedge clk_i); rst_n_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rd_no_write", 32'(mon_bad), 32'd0);
      chk("rd_mscratch", m_mscratch, 32'h0000_0003);
      chk("rd_idle", 32'(busy_o), 32'd0);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
